// File: rtl/riscv_uart_peripheral.sv
// rtl/riscv_uart_peripheral.sv - memory-mapped 8N1 UART responder with TX FIFO; optional receiver under UART_RX_EN
module riscv_uart_peripheral #(
  parameter int          TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_data_in,
  input  logic        uart_configure,
  output logic [31:0] uart_data_out,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_RXDATA = 2'd3;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Bus decode
  logic       sel;
  logic [1:0] off;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_baud;
  logic       wr_rxdata;

  assign sel       = (uart_addr[31:28] == 4'd2);
  assign off       = uart_addr[3:2];
  assign wr_txdata = sel && uart_configure && (off == OFF_TXDATA);
  assign wr_status = sel && uart_configure && (off == OFF_STATUS);
  assign wr_baud   = sel && uart_configure && (off == OFF_BAUD);
  assign wr_rxdata = sel && uart_configure && (off == OFF_RXDATA);

  // Registers and status
  logic [15:0] baud_div;
  logic        tx_ovf;
  logic        tx_busy;
  logic        rx_valid;
  logic [31:0] rx_word;
  logic [31:0] status_word;

  // TX FIFO
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        tx_pop;
  logic        push_ok;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = wr_txdata && (!fifo_full || tx_pop);

  // TX serialiser state
  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shreg;
  logic        tx_line;
  logic        tx_tick;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_pop  = !fifo_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_tick));
  assign tx_busy = (tx_state != TX_IDLE);
  assign uart_tx = tx_line;

  assign status_word = {27'b0, tx_ovf, rx_valid, tx_busy, fifo_full, fifo_empty};

  // BAUDDIV register; the serialiser picks up a new value at its next bit boundary
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      baud_div <= DEFAULT_DIV;
    end else if (wr_baud) begin
      baud_div <= uart_data_in[15:0];
    end
  end

  // Sticky overflow flag: set by a dropped push, cleared by any STATUS write
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      tx_ovf <= 1'b0;
    end else if (wr_status) begin
      tx_ovf <= 1'b0;
    end else if (wr_txdata && !push_ok) begin
      tx_ovf <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr[AW-1:0]] <= uart_data_in[7:0];
    end
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // TX frame FSM: start bit, 8 data bits LSB first, stop bit, chaining frames while data waits
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shreg <= 8'd0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (tx_pop) begin
            tx_shreg <= fifo_mem[rd_ptr[AW-1:0]];
            tx_line  <= 1'b0;
            tx_cnt   <= baud_div;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_line  <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_bit   <= 3'd0;
            tx_cnt   <= baud_div;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= baud_div;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_line  <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt <= baud_div;
            if (tx_pop) begin
              tx_shreg <= fifo_mem[rd_ptr[AW-1:0]];
              tx_line  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_line  <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_RX_EN
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_d;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_byte;
  logic        rx_tick;
  logic        rx_done_ok;
  logic [16:0] rx_half_sum;
  logic [15:0] rx_half;
  logic [15:0] rx_start_cnt;
  logic        unused_bits;

  assign rx_half_sum  = {1'b0, baud_div} + 17'd1;
  assign rx_half      = rx_half_sum[16:1];
  // The edge detector already costs one cycle, so the mid-bit count starts one short.
  assign rx_start_cnt = (rx_half == 16'd0) ? 16'd0 : (rx_half - 16'd1);
  assign rx_tick      = (rx_cnt == 16'd0);
  assign rx_done_ok   = (rx_state == RX_STOP) && rx_tick && rx_s2;
  assign rx_word      = {rx_valid, 23'b0, rx_byte};
  assign unused_bits  = ^{uart_addr[27:4], uart_addr[1:0], uart_data_in[31:16], rx_half_sum[0]};

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // RX frame FSM sampling each bit near its middle
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_cnt   <= rx_start_cnt;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            rx_cnt   <= baud_div;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= baud_div;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Received byte and valid flag; a byte completing on the clearing edge wins
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      rx_valid <= 1'b0;
      rx_byte  <= 8'd0;
    end else if (rx_done_ok) begin
      rx_valid <= 1'b1;
      rx_byte  <= rx_sh;
    end else if (wr_rxdata) begin
      rx_valid <= 1'b0;
    end
  end
`else
  logic unused_bits;

  assign rx_valid    = 1'b0;
  assign rx_word     = 32'd0;
  assign unused_bits = ^{uart_addr[27:4], uart_addr[1:0], uart_data_in[31:16], uart_rx, wr_rxdata};
`endif

  // Read pipeline stage 1: capture the decoded address
  logic       rd_sel_q;
  logic [1:0] rd_off_q;
  logic [31:0] reg_mux;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      rd_sel_q <= 1'b0;
      rd_off_q <= 2'd0;
    end else begin
      rd_sel_q <= sel;
      rd_off_q <= off;
    end
  end

  // Register read mux; TXDATA is write-only and reads 0
  always_comb begin
    reg_mux = 32'd0;
    case (rd_off_q)
      OFF_STATUS: reg_mux = status_word;
      OFF_BAUD:   reg_mux = {16'd0, baud_div};
      OFF_RXDATA: reg_mux = rx_word;
      default:    reg_mux = 32'd0;
    endcase
  end

  // Read pipeline stage 2: registered read data, zero when not selected
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      uart_data_out <= 32'd0;
    end else begin
      uart_data_out <= rd_sel_q ? reg_mux : 32'd0;
    end
  end

endmodule
